// File: rtl/lut_sweep_engine_pkg.sv
// Shared types and helpers for the truth-table sweep engine.
// Holds the FSM state encoding and the binary-to-Gray conversion used on the sweep counter.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest counter the engine ever needs (N_IN max 8, plus one wrap bit).
  localparam int GRAY_MAX_W = 9;

  function automatic logic [GRAY_MAX_W-1:0] gray_of(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/lut_sweep_engine_if.sv
// Beat stream from the sweep engine: one (index, value) pair per accepted handshake.
interface lut_sweep_engine_if #(
  parameter int N_IN = 3
);
  logic            out_valid;
  logic            out_ready;
  logic [N_IN-1:0] out_idx;
  logic            out_bit;

  modport master (output out_valid, output out_idx, output out_bit, input out_ready);
  modport slave  (input out_valid, input out_idx, input out_bit, output out_ready);
endinterface

// File: rtl/lut_sweep_engine_bin2gray.sv
// Combinational binary-to-Gray converter of arbitrary width (up to GRAY_MAX_W).
module bin2gray
  import lut_sweep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = WIDTH'(gray_of(GRAY_MAX_W'(bin_i)));

endmodule

// File: rtl/lut_sweep_engine.sv
// Latches a 2^N_IN-bit truth table and streams every minterm as an (index, value) beat,
// in binary or Gray order, counting the 1-minterms and pulsing done at the end.
module lut_sweep_engine
  import lut_sweep_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int TBL_W = 2**N_IN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                gray_mode,
  input  logic [TBL_W-1:0]    table_in,
  output logic                busy,
  output logic                done,
  output logic [N_IN:0]       ones_count,
  lut_sweep_engine_if.master  out_if
);

  localparam int             CW       = N_IN + 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(TBL_W - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TBL_W-1:0]  table_q, table_d;
  logic              mode_q, mode_d;
  logic [CW-1:0]     ones_q, ones_d;

  logic [N_IN-1:0]   gray_w;
  logic [N_IN-1:0]   idx_sel;
  logic              bit_sel;
  logic              in_run;

  // The wrap bit is always clear while beats are issued, so the low bits fully define the Gray index.
  bin2gray #(.WIDTH(N_IN)) u_bin2gray (
    .bin_i  (cnt_q[N_IN-1:0]),
    .gray_o (gray_w)
  );

  assign in_run  = (state_q == RUN);
  assign idx_sel = mode_q ? gray_w : cnt_q[N_IN-1:0];
  assign bit_sel = table_q[idx_sel];

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    mode_d  = mode_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          table_d = table_in;
          mode_d  = gray_mode;
          cnt_d   = '0;
          ones_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_if.out_ready) begin
          ones_d = ones_q + CW'(bit_sel);
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the latched table is a plain register bank, not a RAM, so it is cleared on reset like the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      table_q <= '0;
      mode_q  <= 1'b0;
      ones_q  <= '0;
    end else begin
      // NOTE: non-blocking updates keep all registers sampling pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      mode_q  <= mode_d;
      ones_q  <= ones_d;
    end
  end

  // Index and value are forced to zero outside RUN so idle outputs stay quiet.
  assign out_if.out_valid = in_run;
  assign out_if.out_idx   = in_run ? idx_sel : '0;
  assign out_if.out_bit   = in_run & bit_sel;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign ones_count       = ones_q;

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Directed bench for lut_sweep_engine: scoreboard of expected beats filled at start,
// drained as beats are accepted; covers order, backpressure, ignore rules, reset and width.
module tb_lut_sweep_engine;

  typedef struct {
    logic [7:0] idx;
    logic       bval;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        start3, gray3;
  logic [7:0]  table3;
  logic        busy3, done3;
  logic [3:0]  ones3;
  logic        start4, gray4;
  logic [15:0] table4;
  logic        busy4, done4;
  logic [4:0]  ones4;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t sb_q[$];

  lut_sweep_engine_if #(.N_IN(3)) if3 ();
  lut_sweep_engine_if #(.N_IN(4)) if4 ();

  lut_sweep_engine #(.N_IN(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start3),
    .gray_mode  (gray3),
    .table_in   (table3),
    .busy       (busy3),
    .done       (done3),
    .ones_count (ones3),
    .out_if     (if3)
  );

  lut_sweep_engine #(.N_IN(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .gray_mode  (gray4),
    .table_in   (table4),
    .busy       (busy4),
    .done       (done4),
    .ones_count (ones4),
    .out_if     (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beat list for a full sweep, built from the truth-table definition.
  task automatic push_sweep(input logic [15:0] tbl, input bit gray, input int n);
    beat_t b;
    for (int i = 0; i < (1 << n); i++) begin
      int k;
      k = gray ? (i ^ (i >> 1)) : i;
      b.idx  = 8'(k);
      b.bval = tbl[k];
      sb_q.push_back(b);
    end
  endtask

  // One N_IN=3 sweep, entered and left on a falling edge.
  task automatic run3(input string tag, input int stall_idx, input int stall_n,
                      input bit inject, input int exp_ones);
    int    beats, dpulse, done_cyc, stalls;
    logic  rdy;
    logic  [3:0] ones_m;
    beat_t b;
    beats = 0; dpulse = 0; done_cyc = 0; stalls = stall_n; ones_m = '0;
    start3 = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      start3 = 1'b0;
      if (done3) begin dpulse++; done_cyc = cyc; end
      if (!busy3) break;
      rdy = 1'b1;
      if (if3.out_valid && stalls > 0 && int'(if3.out_idx) == stall_idx) begin
        rdy = 1'b0;
        stalls--;
        check({tag, " hold_idx"}, 32'(if3.out_idx), 32'(stall_idx));
        check({tag, " hold_bit"}, 32'(if3.out_bit), 32'(sb_q.size() > 0 ? sb_q[0].bval : 1'b0));
        check({tag, " hold_ones"}, 32'(ones3), 32'(ones_m));
      end
      if3.out_ready = rdy;
      if (if3.out_valid && rdy) begin
        if (sb_q.size() == 0) begin
          check({tag, " extra_beat"}, 32'(if3.out_idx), 32'hFFFF_FFFF);
        end else begin
          b = sb_q.pop_front();
          check({tag, " idx"}, 32'(if3.out_idx), 32'(b.idx));
          check({tag, " bit"}, 32'(if3.out_bit), 32'(b.bval));
          ones_m = ones_m + 4'(b.bval);
        end
        beats++;
        if (inject && beats == 3) begin
          start3 = 1'b1;
          table3 = 8'hFF;
        end
      end
      @(posedge clk); @(negedge clk);
    end
    check({tag, " busy_end"}, 32'(busy3), 32'd0);
    check({tag, " beats"}, beats, 32'd8);
    check({tag, " sb_empty"}, sb_q.size(), 32'd0);
    check({tag, " done_pulses"}, dpulse, 32'd1);
    check({tag, " done_cycle"}, done_cyc, 32'(9 + stall_n));
    check({tag, " ones"}, 32'(ones3), 32'(exp_ones));
    sb_q.delete();
  endtask

  initial begin
    int    beats4, dpulse4;
    beat_t b;
    rst_n = 1'b0;
    start3 = 1'b0; gray3 = 1'b0; table3 = 8'h00;
    start4 = 1'b0; gray4 = 1'b0; table4 = 16'h0000;
    if3.out_ready = 1'b0;
    if4.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst busy",  32'(busy3), 32'd0);
    check("rst valid", 32'(if3.out_valid), 32'd0);
    check("rst done",  32'(done3), 32'd0);
    check("rst ones",  32'(ones3), 32'd0);
    check("rst idx",   32'(if3.out_idx), 32'd0);
    check("rst bit",   32'(if3.out_bit), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Binary sweep of f = a & ~(b&c).
    table3 = 8'h70; gray3 = 1'b0;
    push_sweep(16'h0070, 1'b0, 3);
    run3("bin", -1, 0, 1'b0, 3);
    @(negedge clk); @(negedge clk);
    check("idle ones_hold", 32'(ones3), 32'd3);
    check("idle idx", 32'(if3.out_idx), 32'd0);
    check("idle valid", 32'(if3.out_valid), 32'd0);

    // Gray-order sweep of the same table.
    gray3 = 1'b1;
    push_sweep(16'h0070, 1'b1, 3);
    run3("gray", -1, 0, 1'b0, 3);

    // Backpressure: three stalled cycles on index 2.
    gray3 = 1'b0;
    push_sweep(16'h0070, 1'b0, 3);
    run3("bp", 2, 3, 1'b0, 3);

    // Start re-pulse and table change mid-sweep must be ignored.
    table3 = 8'h70;
    push_sweep(16'h0070, 1'b0, 3);
    run3("ign", -1, 0, 1'b1, 3);

    // Reset during the Gray beat at index 4 (last beat; two 1-beats already counted).
    table3 = 8'h70; gray3 = 1'b1;
    if3.out_ready = 1'b1;
    start3 = 1'b1;
    @(posedge clk); @(negedge clk);
    start3 = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (if3.out_valid && if3.out_idx == 3'd4) break;
      @(posedge clk); @(negedge clk);
    end
    check("mid valid_at_4", 32'(if3.out_valid), 32'd1);
    check("mid ones_before", 32'(ones3), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mrst busy",  32'(busy3), 32'd0);
    check("mrst valid", 32'(if3.out_valid), 32'd0);
    check("mrst done",  32'(done3), 32'd0);
    check("mrst ones",  32'(ones3), 32'd0);
    check("mrst idx",   32'(if3.out_idx), 32'd0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      check("mrst no_done", 32'(done3), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst no_done", 32'(done3), 32'd0);
    gray3 = 1'b0;
    push_sweep(16'h0070, 1'b0, 3);
    run3("after_rst", -1, 0, 1'b0, 3);

    // Width boundary: N_IN=4 with an all-ones table.
    table4 = 16'hFFFF;
    if4.out_ready = 1'b1;
    push_sweep(16'hFFFF, 1'b0, 4);
    beats4 = 0; dpulse4 = 0;
    start4 = 1'b1;
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (done4) dpulse4++;
      if (!busy4) break;
      if (if4.out_valid) begin
        if (sb_q.size() == 0) begin
          check("w4 extra_beat", 32'(if4.out_idx), 32'hFFFF_FFFF);
        end else begin
          b = sb_q.pop_front();
          check("w4 idx", 32'(if4.out_idx), 32'(b.idx));
          check("w4 bit", 32'(if4.out_bit), 32'(b.bval));
        end
        beats4++;
      end
      @(posedge clk); @(negedge clk);
    end
    check("w4 busy_end", 32'(busy4), 32'd0);
    check("w4 beats", beats4, 32'd16);
    check("w4 done_pulses", dpulse4, 32'd1);
    check("w4 ones", 32'(ones4), 32'h10);
    sb_q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lut_sweep_engine.md
Name: lut_sweep_engine

Overview:
- Parametrised sequential truth-table evaluator. Latches a 2^N_IN-bit truth table, then streams every minterm as an (index, value) beat over a valid/ready interface.
- Supports binary or Gray-code sweep order, counts the 1-minterms, and pulses done when the sweep ends.
- Replaces hand-written fixed 3-input gate functions plus bench-side counter loops; used as a reusable function generator and self-check source.

Parameters:
- N_IN, 3, number of function inputs (1..8).
- TBL_W, 2**N_IN, truth-table width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a sweep; sampled only in IDLE.
- gray_mode  input  1  0 = binary order, 1 = Gray order; latched at start.
- table_in  input  TBL_W  truth table; bit i = f(index i); latched at start.
- busy  output  1  high in RUN and DONE.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts the beat.
- out_idx  output  N_IN  minterm index of the current beat.
- out_bit  output  1  table_latched[out_idx].
- done  output  1  one-cycle pulse after the last beat is accepted.
- ones_count  output  N_IN+1  number of accepted beats with out_bit=1 in the current/last sweep.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; counter, table_latched, mode_latched and ones_count = 0. busy, out_valid and done = 0. out_idx=0, out_bit=0.
- Counter: N_IN+1 bits wide, so no ambiguity at the last index.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch table_in and gray_mode; counter=0; ones_count=0.
  - RUN from cycle k+1.
- IDLE, start=0: remain in IDLE; outputs hold, and ones_count keeps its last value.
- RUN:
  - out_valid=1.
  - out_idx = counter (binary) or counter ^ (counter>>1) (Gray), truncated to N_IN bits.
  - out_bit = table_latched[out_idx].
  - Beat accepted on an edge with out_valid & out_ready: ones_count += out_bit; counter += 1.
  - If the accepted beat had counter = 2^N_IN-1, go to DONE.
- Backpressure: while out_valid=1 and out_ready=0, out_idx, out_bit and ones_count are stable. No beat is dropped or duplicated.
- DONE: out_valid=0, done=1 for exactly one cycle, then IDLE.
- Latency, out_ready held high: first beat in cycle k+1, last in cycle k+2^N_IN, done in cycle k+2^N_IN+1, busy low from k+2^N_IN+2.
- start while busy=1: ignored; no restart, no relatch.
- table_in or gray_mode changing during RUN: no effect.
- out_ready while not in RUN: ignored.
- Reset mid-sweep: immediate return to IDLE with reset values. No done pulse is generated.
- All outputs derive from registers only; no combinational path from start or out_ready to outputs.

Decomposition:
- Package lut_sweep_pkg: state enum (IDLE, RUN, DONE); function gray_of(bin).
- One sub-module: bin2gray (parametrised width, combinational), instantiated on the counter.

Test Plan:
- Binary sweep: N_IN=3, table_in=8'h70 (f = a & ~(b&c), a = idx[2]), gray_mode=0, out_ready=1, start pulse → out_idx 0..7, out_bit 0,0,0,0,1,1,1,0; done in the 9th cycle after start; ones_count=3.
- Gray sweep: same table, gray_mode=1 → out_idx 0,1,3,2,6,7,5,4; out_bit 0,0,0,0,1,0,1,1; ones_count=3.
- Backpressure: binary sweep, out_ready=0 for 3 cycles while out_idx=2 → idx 2 / bit 0 held all 3 cycles; exactly 8 accepted beats; done delayed by 3 cycles; ones_count=3.
- Ignore rules: start re-pulsed and table_in changed to 8'hFF at beat 3 → sweep continues on 8'h70; ones_count=3; single done pulse.
- Reset mid-sweep: rst_n low during beat idx 4 → busy, out_valid, done and ones_count = 0 at once, and no done pulse. A new start then sweeps from idx 0.
- Width boundary: N_IN=4, table_in=16'hFFFF → 16 beats, all out_bit=1, ones_count=16 (5'b10000, no overflow).
